// File: rtl/output_port_scheduler.sv
// Output-port packet scheduler: round-robin over four requesters at packet granularity, credit-paced flit reads.
// Optional OPS_CREDIT_BYPASS_EN lets a same-cycle credit pulse enable a read while the credit count is zero.
module output_port_scheduler #(
    parameter  int PKT_FLITS = 4,
    parameter  int CREDITS   = 4,
    localparam int CW        = $clog2(CREDITS + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    req_i,
    input  logic          credit_i,
    output logic [3:0]    grant_o,
    output logic [3:0]    read_o,
    output logic [2:0]    mux_sel_o,
    output logic          valid_o,
    output logic          pkt_done_o,
    output logic [CW-1:0] credits_o,
    output logic          credit_err_o
);
    typedef enum logic [0:0] {IDLE = 1'b0, XFER = 1'b1} state_e;

    localparam logic [CW-1:0] CRED_MAX  = CW'(CREDITS);
    localparam logic [3:0]    LAST_FLIT = 4'(PKT_FLITS - 1);

    state_e        state_q, state_d;
    logic [1:0]    owner_q, owner_d;
    logic [1:0]    rr_ptr_q, rr_ptr_d;
    logic [3:0]    flit_cnt_q, flit_cnt_d;
    logic [3:0]    grant_q, grant_d;
    logic [2:0]    mux_sel_q, mux_sel_d;
    logic [CW-1:0] credits_q, credits_d;
    logic          credit_err_q, credit_err_d;

    logic          send_ok_s;
    logic [3:0]    read_s;
    logic          pkt_done_s;
    logic          pick_vld_s;
    logic [1:0]    pick_idx_s;

    // Round-robin pick: lowest offset from rr_ptr wins, so scan offsets from highest down.
    always_comb begin
        pick_vld_s = 1'b0;
        pick_idx_s = rr_ptr_q;
        for (int i = 3; i >= 0; i--) begin
            if (req_i[rr_ptr_q + 2'(i)]) begin
                pick_vld_s = 1'b1;
                pick_idx_s = rr_ptr_q + 2'(i);
            end else begin
                pick_vld_s = pick_vld_s;
            end
        end
    end

    // Read permission from the credit count (plus same-cycle credit when bypass is built in).
    always_comb begin
`ifdef OPS_CREDIT_BYPASS_EN
        send_ok_s = (credits_q != {CW{1'b0}}) || credit_i;
`else
        send_ok_s = (credits_q != {CW{1'b0}});
`endif
    end

    // Arbitration / transfer FSM next-state and flit strobes.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        flit_cnt_d = flit_cnt_q;
        grant_d    = grant_q;
        mux_sel_d  = mux_sel_q;
        read_s     = 4'b0000;
        pkt_done_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_vld_s) begin
                    state_d    = XFER;
                    owner_d    = pick_idx_s;
                    flit_cnt_d = 4'd0;
                    grant_d    = 4'b0001 << pick_idx_s;
                    mux_sel_d  = {1'b0, pick_idx_s};
                end else begin
                    state_d = IDLE;
                end
            end
            XFER: begin
                if (req_i[owner_q] && send_ok_s) begin
                    read_s = 4'b0001 << owner_q;
                    if (flit_cnt_q == LAST_FLIT) begin
                        pkt_done_s = 1'b1;
                        rr_ptr_d   = owner_q + 2'd1;
                        state_d    = IDLE;
                        flit_cnt_d = 4'd0;
                        grant_d    = 4'b0000;
                        mux_sel_d  = 3'd7;
                    end else begin
                        flit_cnt_d = flit_cnt_q + 4'd1;
                    end
                end else begin
                    state_d = XFER;
                end
            end
            default: begin
                state_d   = IDLE;
                grant_d   = 4'b0000;
                mux_sel_d = 3'd7;
            end
        endcase
    end

    // Credit counter with saturation at CREDITS and sticky overflow flag.
    always_comb begin
        credits_d    = credits_q;
        credit_err_d = credit_err_q | (credit_i && (credits_q == CRED_MAX));
        case ({credit_i, |read_s})
            2'b10: begin
                if (credits_q == CRED_MAX) begin
                    credits_d = credits_q;
                end else begin
                    credits_d = credits_q + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            2'b01:   credits_d = credits_q - {{(CW-1){1'b0}}, 1'b1};
            default: credits_d = credits_q;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            owner_q      <= 2'd0;
            rr_ptr_q     <= 2'd0;
            flit_cnt_q   <= 4'd0;
            grant_q      <= 4'b0000;
            mux_sel_q    <= 3'd7;
            credits_q    <= CRED_MAX;
            credit_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            rr_ptr_q     <= rr_ptr_d;
            flit_cnt_q   <= flit_cnt_d;
            grant_q      <= grant_d;
            mux_sel_q    <= mux_sel_d;
            credits_q    <= credits_d;
            credit_err_q <= credit_err_d;
        end
    end

    assign grant_o      = grant_q;
    assign mux_sel_o    = mux_sel_q;
    assign read_o       = read_s;
    assign valid_o      = |read_s;
    assign pkt_done_o   = pkt_done_s;
    assign credits_o    = credits_q;
    assign credit_err_o = credit_err_q;
endmodule

// File: tb/tb_output_port_scheduler.sv
// Scoreboard bench for output_port_scheduler: a packet-level reference model queues expected outputs per cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_output_port_scheduler;
    localparam int TP  = 4;
    localparam int TC  = 4;
    localparam int TCW = $clog2(TC + 1);

    typedef struct packed {
        logic [3:0]     grant;
        logic [3:0]     read;
        logic [2:0]     mux;
        logic           valid;
        logic           done;
        logic [TCW-1:0] cred;
        logic           err;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset;
    logic [3:0]     req_i;
    logic           credit_i;
    logic [3:0]     grant_o;
    logic [3:0]     read_o;
    logic [2:0]     mux_sel_o;
    logic           valid_o;
    logic           pkt_done_o;
    logic [TCW-1:0] credits_o;
    logic           credit_err_o;

    output_port_scheduler #(.PKT_FLITS(TP), .CREDITS(TC)) dut (
        .clk(clk), .reset(reset), .req_i(req_i), .credit_i(credit_i),
        .grant_o(grant_o), .read_o(read_o), .mux_sel_o(mux_sel_o), .valid_o(valid_o),
        .pkt_done_o(pkt_done_o), .credits_o(credits_o), .credit_err_o(credit_err_o)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;
    int   grant_seq[$];

    // Reference model: owner = -1 means no packet in flight.
    int m_owner = -1;
    int m_rr    = 0;
    int m_flits = 0;
    int m_cred  = TC;
    bit m_err   = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic step(input logic [3:0] r, input logic c, input logic rst);
        exp_t e;
        bit   can_send;
        bit   rd;
        @(posedge clk);
        #1;
        req_i    = r;
        credit_i = c;
        reset    = rst;
`ifdef OPS_CREDIT_BYPASS_EN
        can_send = (m_cred > 0) || c;
`else
        can_send = (m_cred > 0);
`endif
        rd      = (m_owner >= 0) && r[m_owner] && can_send;
        e.grant = (m_owner >= 0) ? 4'(1 << m_owner) : 4'd0;
        e.mux   = (m_owner >= 0) ? 3'(m_owner) : 3'd7;
        e.read  = rd ? 4'(1 << m_owner) : 4'd0;
        e.valid = rd;
        e.done  = rd && (m_flits == TP - 1);
        e.cred  = TCW'(m_cred);
        e.err   = m_err;
        exp_q.push_back(e);
        if (!rst) begin
            m_owner = -1; m_rr = 0; m_flits = 0; m_cred = TC; m_err = 1'b0;
        end else begin
            if (c && m_cred == TC) m_err = 1'b1;
            m_cred = m_cred + int'(c) - int'(rd);
            if (m_cred > TC) m_cred = TC;
            if (m_owner < 0) begin
                for (int k = 0; k < 4; k++) begin
                    if (m_owner < 0 && r[(m_rr + k) % 4]) m_owner = (m_rr + k) % 4;
                end
                m_flits = 0;
                if (m_owner >= 0) grant_seq.push_back(m_owner);
            end else if (rd) begin
                m_flits++;
                if (m_flits == TP) begin
                    m_rr    = (m_owner + 1) % 4;
                    m_owner = -1;
                end
            end
        end
    endtask

    // Monitor: compare every queued expectation against the DUT mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("grant",   int'(grant_o),      int'(e.grant));
                chk("read",    int'(read_o),       int'(e.read));
                chk("mux_sel", int'(mux_sel_o),    int'(e.mux));
                chk("valid",   int'(valid_o),      int'(e.valid));
                chk("done",    int'(pkt_done_o),   int'(e.done));
                chk("credits", int'(credits_o),    int'(e.cred));
                chk("err",     int'(credit_err_o), int'(e.err));
            end
        end
    end

    initial begin
        logic [3:0] r;
        logic       c;
        reset = 1'b0; req_i = 4'd0; credit_i = 1'b0;
        step(4'd0, 1'b0, 1'b0);
        step(4'd0, 1'b0, 1'b0);
        // Single packet on requester 2, credits run out
        for (int i = 0; i < 8; i++) step(4'b0100, 1'b0, 1'b1);
        // Return credits while idle, then overflow
        for (int i = 0; i < 4; i++) step(4'b0000, 1'b1, 1'b1);
        step(4'b0000, 1'b1, 1'b1);
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0000, 1'b1, 1'b1);
        // Mid-packet reset
        for (int i = 0; i < 3; i++) step(4'b1111, 1'b0, 1'b1);
        step(4'b1111, 1'b0, 1'b0);
        step(4'b1111, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b0);
        // Round-robin fairness with credit every cycle
        grant_seq.delete();
        for (int i = 0; i < 25; i++) step(4'b1111, 1'b1, 1'b1);
        chk("rr_count", (grant_seq.size() >= 5) ? 1 : 0, 1);
        for (int i = 0; i < 5 && i < grant_seq.size(); i++) chk("rr_order", grant_seq[i], i % 4);
        // Source stall: requester 1 drops while 3 waits
        step(4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(4'b1010, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(4'b1000, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(4'b1010, 1'b1, 1'b1);
        // Credit starvation: drain, wait, single credit pulse
        for (int i = 0; i < 6; i++) step(4'b0001, 1'b0, 1'b1);
        step(4'b0001, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(4'b0001, 1'b0, 1'b1);
        // Randomized traffic
        r = 4'd0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            c = ($urandom_range(0, 99) < 45);
            step(r, c, ($urandom_range(0, 299) != 0));
        end
        @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/output_port_scheduler.md
# output_port_scheduler

Per-output-port packet scheduler for the NoC router. One instance sits on each output port. It shares the port's crossbar mux among the four input ports that can route to it, using round-robin arbitration at packet granularity. It holds the grant for a whole packet, paces flit transfer against a downstream credit counter, and drives the pop strobes to the input buffers and the crossbar mux select.

## Interface
Parameters:
- PKT_FLITS, 4: flits per packet, fixed length; legal range 2..16.
- CREDITS, 4: downstream input-buffer depth, and the credit counter's reset value; legal range 1..15.
- CW, $clog2(CREDITS+1): credit counter width; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset.
- req_i  in  4  req_i[k]: requester k's buffer is non-empty and its next-hop register selects this port.
- credit_i  in  1  one-cycle pulse; downstream freed one buffer slot.
- grant_o  out  4  one-hot current owner; 4'b0000 when idle.
- read_o  out  4  one-hot pop strobe to the owner's buffer; one flit per asserted cycle.
- mux_sel_o  out  3  crossbar select: owner index 0..3; 3'd7 when idle.
- valid_o  out  1  flit on the crossbar output is valid; equals |read_o.
- pkt_done_o  out  1  pulse on the cycle the last flit of a packet is read.
- credits_o  out  CW  current credit count.
- credit_err_o  out  1  sticky; set when a credit arrives while the count is already CREDITS.

## Operation
- FSM states: IDLE, XFER.
- IDLE:
  - If req_i != 0, pick the first set bit at or after rr_ptr, searching upward modulo 4.
  - Register that requester as owner g, clear flit_cnt, go to XFER.
  - Otherwise stay in IDLE.
- XFER:
  - read_o[g] = req_i[g] && send_ok, where send_ok = (credits > 0).
  - Every other read_o bit is 0.
  - A deasserted req_i[g] stalls the packet. The grant is held; there is no timeout.
  - Each read increments flit_cnt.
  - A read with flit_cnt == PKT_FLITS-1 does three things:
    - pulses pkt_done_o;
    - sets rr_ptr = (g+1) mod 4;
    - next state is IDLE, with grant_o clearing the following cycle.
- Credit counter: next = credits + credit_i − (|read_o).
  - A simultaneous credit and read leaves the count unchanged.
  - A credit at count == CREDITS is dropped, the count stays saturated, and credit_err_o is set.
  - The counter never underflows, because send_ok gates every read.
- Non-owner requesters are ignored during XFER. Their req_i changes have no effect until the next IDLE cycle.
- Reset (reset == 0 at an edge), mid-packet included:
  - state = IDLE, rr_ptr = 0, flit_cnt = 0;
  - credits = CREDITS, credit_err_o = 0.
  - A packet in progress is abandoned; the flits already read are not recovered.

## Timing
- Reset values:
  - grant_o = 0, read_o = 0, mux_sel_o = 3'd7;
  - valid_o = 0, pkt_done_o = 0;
  - credits_o = CREDITS, credit_err_o = 0.
- grant_o, mux_sel_o, credits_o and credit_err_o are registered.
- read_o, valid_o and pkt_done_o are combinational from registered state plus req_i (and credit_i when the bypass is compiled in).
- Latency: if req_i rises in cycle t while in IDLE, grant_o is set in t+1 and the first read_o is in t+1, given credit is available.
- Minimum packet occupancy is PKT_FLITS cycles plus one IDLE arbitration cycle. Back-to-back packets therefore have exactly one bubble.
- A credit_i pulse in cycle t becomes visible in credits_o at t+1.

## Configuration
- OPS_CREDIT_BYPASS_EN:
  - Defined: send_ok = (credits > 0) || credit_i. A credit arriving in the same cycle as the count sits at 0 allows the read, and the count stays at 0.
  - Undefined: send_ok = (credits > 0). A same-cycle credit is only usable the next cycle.
- Both settings keep the saturation and underflow rules above.

## Test plan
- Single packet:
  - Stimulus: reset, then req_i = 4'b0100 held, with PKT_FLITS = 4 and CREDITS = 4.
  - Required: grant_o = 4'b0100 and mux_sel_o = 2 from cycle 1; read_o[2] high in cycles 1–4; pkt_done_o in cycle 4; credits_o = 0 afterwards; IDLE in cycle 5.
- Round-robin fairness:
  - Stimulus: req_i = 4'b1111 held, with credit_i returned every cycle.
  - Required: owners are granted in order 0, 1, 2, 3, 0, with one idle cycle between packets.
- Credit starvation:
  - Stimulus: CREDITS = 2, one 4-flit packet, no credit_i until cycle 6, then a single pulse.
  - Required: reads in cycles 1–2; stall with grant held; a third read in cycle 7 (cycle 6 with OPS_CREDIT_BYPASS_EN); credits_o never negative.
- Source stall:
  - Stimulus: req_i[1] drops for 3 cycles after the 2nd flit while req_i[3] = 1.
  - Required: grant_o stays 4'b0010; no read_o[3]; the packet completes after req_i[1] returns.
- Overflow and reset:
  - Stimulus: credit_i while credits_o = CREDITS.
  - Required: credits_o is unchanged and credit_err_o = 1 (sticky).
  - Stimulus: assert reset mid-packet.
  - Required: all outputs return to their reset values on the next edge.
